led_arbiter: RTL and testbench
==============================

# led_arbiter

Shares the board's 8-bit LED bank among up to `NREQ` on-chip requesters (status monitors, debug counters, blinky-style heartbeats). Each requester drives an 8-bit pattern and a request line. The arbiter grants the LEDs round-robin with a guaranteed minimum display time, measured in prescaled ticks of the 25 MHz clock. It sits between the requesters and the `led[7:0]` pins in the top level.

## Interface
- `NREQ`, 4: number of requesters (2..8).
- `PRESCALE`, 2**20: clk cycles per display tick (about 42 ms at 25 MHz).
- `HOLD_TICKS`, 8: ticks a grant is held before it may be pre-empted (≥1).

Ports:
- `clk`  in  1  system clock, 25 MHz.
- `rst`  in  1  reset; synchronous, active-high.
- `req`  in  NREQ  request, level-sensitive, one bit per requester.
- `pattern`  in  NREQ*8  requester i's pattern is bits [8i+7:8i].
- `led`  out  8  LED drive, registered.
- `grant`  out  NREQ  one-hot current owner, registered; all zero when idle.
- `busy`  out  1  high while any grant is active.

## Operation
- Tick generator:
  - counts 0..PRESCALE-1 and wraps;
  - `tick` is a 1-cycle pulse when the count equals PRESCALE-1;
  - free-running, and cleared only by reset.
- States are IDLE and OWN.
- IDLE:
  - `led`=0, `grant`=0, `busy`=0.
  - If any `req` bit is high, pick the winner by round-robin starting at `last+1` modulo NREQ.
  - Move to OWN, set `grant`, clear `hold_cnt`, and record `last` = winner.
- OWN:
  - Each cycle, `led` <= pattern slice of the owner, so pattern changes are shown live with 1-cycle lag.
  - `hold_cnt` increments on each `tick` and saturates at HOLD_TICKS.
- Switch event, evaluated each cycle in OWN:
  - (a) the owner drops `req` (release), or
  - (b) `hold_cnt`==HOLD_TICKS and some other `req` bit is high (pre-emption).
- On a switch event, round-robin arbitration runs from owner+1:
  - If a winner exists, the grant moves to it directly at the same edge, with no idle cycle. `led` loads the new pattern, and `hold_cnt` clears.
  - If no winner exists, go to IDLE and drive `led`=0.
- Owner still requesting at expiry with no competitors: the grant is kept and `hold_cnt` stays saturated. A later request from another requester pre-empts on the next cycle.
- Simultaneous release and expiry: treated as release, so the owner is excluded from arbitration.
- Requests from the owner itself never count as competitors.

## Timing
- Reset values:
  - `led`=0, `grant`=0, `busy`=0;
  - state IDLE, `last`=NREQ-1 (so requester 0 wins first);
  - tick count 0, `hold_cnt`=0.
- Request in IDLE at edge n: `grant`, `busy` and `led` are valid after edge n+1 (1-cycle latency).
- Release at edge m (owner `req` low): the new grant, or IDLE, takes effect after edge m+1.
- Minimum hold is HOLD_TICKS ticks from grant. The first tick may arrive anywhere from 1 to PRESCALE cycles after grant, so the real hold is between (HOLD_TICKS-1)·PRESCALE+1 and HOLD_TICKS·PRESCALE cycles.
- `rst` mid-grant: all outputs return to reset values after the next edge. Outstanding requests are re-arbitrated from requester 0 on the cycle after `rst` falls.

## Configuration
- Macro: `LED_ARBITER_PWM_EN`.
- Defined:
  - adds input `duty` (4 bits) and a free-running 4-bit PWM counter (reset 0);
  - `led` = `led_q` & {8{pwm_cnt < duty}};
  - `duty`=0 gives LEDs off, `duty`=15 gives 15/16 brightness;
  - the gating is applied after the registered `led_q`, so `led` stays glitch-free.
- Undefined: no `duty` port, no PWM logic, and `led` = `led_q`.

## Structure
- Package `led_arbiter_pkg`: `LED_W`=8, state enum (`ST_IDLE`, `ST_OWN`), and a round-robin pick function (request vector plus start index, returning index and valid).
- Sub-module `led_tick_gen` (parameter PRESCALE; ports clk, rst, tick). It is reusable by other board blocks.

## Test plan
Use PRESCALE=4 and HOLD_TICKS=2 unless noted.
- Reset, then `req`=0001 with pattern0=0xA5:
  - `grant`=0001 and `led`=0xA5 one cycle after request;
  - `busy`=1.
- Owner 0 holds while `req`=0011:
  - no switch before `hold_cnt`==2;
  - the cycle after expiry, `grant`=0010 and `led`=pattern1, with no zero cycle.
- `req`=1111 held for a long period:
  - grants rotate 0→1→2→3→0;
  - each grant lasts the hold window.
- Owner 2 drops `req` mid-hold while `req`=0001:
  - `grant`=0001 on the next edge;
  - if `req`=0000 instead: IDLE, `led`=0x00, `busy`=0.
- Single requester held past expiry: the grant persists. Then assert a second `req`: the switch happens 1 cycle later.
- Assert `rst` during OWN: all outputs 0 after the next edge.
- With `LED_ARBITER_PWM_EN` defined: `duty`=4 and pattern 0xFF gives `led`=0xFF for exactly 4 of every 16 cycles.

Source files
------------

// File: rtl/led_arbiter_pkg.sv
// led_arbiter_pkg: shared types and helpers for the LED bank arbiter.
//   LED_W     - width of the LED bank
//   MAX_NREQ  - widest requester vector the arbiter supports
//   state_e   - arbiter FSM states
//   rr_pick   - round-robin search over a request vector from a start index
// Optional feature macro (used by the interface and top): LED_ARBITER_PWM_EN.
package led_arbiter_pkg;

  localparam int LED_W    = 8;
  localparam int MAX_NREQ = 8;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_OWN  = 1'b1
  } state_e;

  typedef struct packed {
    logic       valid;
    logic [2:0] idx;
  } rr_pick_t;

  // Scans nreq positions starting at 'start' and wrapping at nreq; the first
  // set request bit wins. 'start' is always below nreq, so a single
  // subtraction is enough to wrap.
  function automatic rr_pick_t rr_pick(input logic [MAX_NREQ-1:0] req,
                                       input logic [2:0]          start,
                                       input int                  nreq);
    rr_pick_t res;
    int       cand;
    res = '0;
    for (int i = 0; i < MAX_NREQ; i++) begin
      cand = int'(start) + i;
      if (cand >= nreq) cand = cand - nreq;
      if (i < nreq && !res.valid && req[cand[2:0]]) begin
        res.valid = 1'b1;
        res.idx   = cand[2:0];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/led_arbiter_if.sv
// led_arbiter_if: requester-side bundle of the LED arbiter.
//   req     - one request line per requester (level-sensitive)
//   pattern - requester i drives bits [8i+7:8i]
//   led     - LED bank drive
//   grant   - one-hot current owner, zero when idle
//   busy    - high while a grant is active
//   duty    - PWM brightness, present only with LED_ARBITER_PWM_EN
// master: requester/top-level side.  slave: the arbiter.
interface led_arbiter_if #(
  parameter int NREQ = 4
);
  import led_arbiter_pkg::*;

  logic [NREQ-1:0]       req;
  logic [NREQ*LED_W-1:0] pattern;
  logic [LED_W-1:0]      led;
  logic [NREQ-1:0]       grant;
  logic                  busy;

`ifdef LED_ARBITER_PWM_EN
  logic [3:0]            duty;

  modport master (output req, pattern, duty, input led, grant, busy);
  modport slave  (input req, pattern, duty, output led, grant, busy);
`else
  modport master (output req, pattern, input led, grant, busy);
  modport slave  (input req, pattern, output led, grant, busy);
`endif

endinterface

// File: rtl/led_tick_gen.sv
// led_tick_gen: free-running prescaler producing a one-cycle tick every
// PRESCALE clock cycles. Reusable by other board blocks.
//   clk  - system clock
//   rst  - synchronous, active-high reset (count returns to 0)
//   tick - high for the one cycle in which the count equals PRESCALE-1
module led_tick_gen #(
  parameter int unsigned PRESCALE = 1 << 20
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick  = (cnt_q == CW'(PRESCALE - 1));
  assign cnt_d = tick ? '0 : cnt_q + CW'(1);

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/led_arbiter.sv
// led_arbiter: shares the 8-bit LED bank among NREQ requesters, round-robin,
// with a minimum display time of HOLD_TICKS prescaled ticks per grant.
//   clk  - system clock (25 MHz)
//   rst  - synchronous, active-high reset
//   bus  - led_arbiter_if.slave: req, pattern in; led, grant, busy out
//          (plus duty in when LED_ARBITER_PWM_EN is defined)
// Parameters: NREQ (2..8), PRESCALE (clk cycles per tick), HOLD_TICKS (>=1).
// Macro LED_ARBITER_PWM_EN adds a 16-step PWM brightness gate after led_q.
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_IDLE | no owner; LEDs dark; arbitrates any request from last+1
// ST_OWN  | last_q owns the LEDs; shows its pattern live, counts hold ticks
module led_arbiter
  import led_arbiter_pkg::*;
#(
  parameter int          NREQ       = 4,
  parameter int unsigned PRESCALE   = 1 << 20,
  parameter int unsigned HOLD_TICKS = 8
) (
  input  logic         clk,
  input  logic         rst,
  led_arbiter_if.slave bus
);

  localparam int HW = $clog2(HOLD_TICKS + 1);

  state_e           state_q, state_d;
  logic [2:0]       last_q, last_d;
  logic [NREQ-1:0]  grant_q, grant_d;
  logic [LED_W-1:0] led_q, led_d;
  logic [HW-1:0]    hold_q, hold_d;

  logic                tick;
  logic [LED_W-1:0]    pat_a [MAX_NREQ];
  logic [MAX_NREQ-1:0] req_w, own_w, comp_w, oh_w;
  logic [2:0]          next_start;
  logic                release_w, expired_w;
  rr_pick_t            pick;

  led_tick_gen #(.PRESCALE(PRESCALE)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  // Pattern slices padded to MAX_NREQ so a 3-bit index is always in range.
  for (genvar g = 0; g < MAX_NREQ; g++) begin : g_pat
    if (g < NREQ) begin : g_used
      assign pat_a[g] = bus.pattern[g*LED_W +: LED_W];
    end else begin : g_pad
      assign pat_a[g] = '0;
    end
  end

  assign req_w      = MAX_NREQ'(bus.req);
  assign own_w      = MAX_NREQ'(grant_q);
  // The owner's own request never counts as competition.
  assign comp_w     = req_w & ~own_w;
  assign release_w  = ~|(req_w & own_w);
  assign expired_w  = (hold_q == HW'(HOLD_TICKS));
  assign next_start = (last_q == 3'(NREQ - 1)) ? 3'd0 : last_q + 3'd1;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    grant_d = grant_q;
    led_d   = led_q;
    hold_d  = hold_q;
    pick    = '0;
    oh_w    = '0;

    case (state_q)
      ST_IDLE: begin
        grant_d = '0;
        led_d   = '0;
        pick    = rr_pick(req_w, next_start, NREQ);
        if (pick.valid) begin
          oh_w    = MAX_NREQ'(1) << pick.idx;
          state_d = ST_OWN;
          last_d  = pick.idx;
          grant_d = oh_w[NREQ-1:0];
          led_d   = pat_a[pick.idx];
          hold_d  = '0;
        end
      end

      ST_OWN: begin
        led_d = pat_a[last_q];
        if (tick && !expired_w) hold_d = hold_q + HW'(1);
        // Release takes priority over expiry; either way the owner is masked
        // out of the search, so it can only be re-granted via IDLE.
        if (release_w || (expired_w && |comp_w)) begin
          pick   = rr_pick(comp_w, next_start, NREQ);
          hold_d = '0;
          if (pick.valid) begin
            oh_w    = MAX_NREQ'(1) << pick.idx;
            last_d  = pick.idx;
            grant_d = oh_w[NREQ-1:0];
            led_d   = pat_a[pick.idx];
          end else begin
            state_d = ST_IDLE;
            grant_d = '0;
            led_d   = '0;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
        led_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      last_q  <= 3'(NREQ - 1);
      grant_q <= '0;
      led_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      grant_q <= grant_d;
      led_q   <= led_d;
      hold_q  <= hold_d;
    end
  end

  assign bus.grant = grant_q;
  assign bus.busy  = (state_q == ST_OWN);

`ifdef LED_ARBITER_PWM_EN
  logic [3:0] pwm_cnt_q, pwm_cnt_d;

  assign pwm_cnt_d = pwm_cnt_q + 4'd1;

  always_ff @(posedge clk) begin
    if (rst) pwm_cnt_q <= '0;
    else     pwm_cnt_q <= pwm_cnt_d;
  end

  // Gate after the register so the pins only change on clock edges.
  assign bus.led = led_q & {LED_W{pwm_cnt_q < bus.duty}};
`else
  assign bus.led = led_q;
`endif

endmodule

// File: tb/tb_led_arbiter.sv
// tb_led_arbiter: directed-vector bench for led_arbiter with NREQ=4,
// PRESCALE=4, HOLD_TICKS=2. Cycle numbers are counted from the last edge
// with rst high; with PRESCALE=4 a tick is sampled at edges 4, 8, 12, ...
// Covers LED_ARBITER_PWM_EN as well when that macro is defined.
module tb_led_arbiter;

  localparam int NREQ = 4;

  logic clk;
  logic rst;
  int   cyc;
  int   n_checks;
  int   n_fail;
  int   pwm_m;

  led_arbiter_if #(.NREQ(NREQ)) bus ();

  led_arbiter #(
    .NREQ       (NREQ),
    .PRESCALE   (4),
    .HOLD_TICKS (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_val(input string tag, input logic [31:0] obs,
                           input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One clock; pwm_m tracks what the PWM counter holds after this edge.
  task automatic step();
    @(posedge clk);
    pwm_m = rst ? 0 : ((pwm_m + 1) % 16);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int n);
    while (cyc < n) step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    cyc = 0;
    rst = 1'b0;
  endtask

  function automatic logic [7:0] exp_led(input logic [7:0] v);
`ifdef LED_ARBITER_PWM_EN
    return (pwm_m < int'(bus.duty)) ? v : 8'h00;
`else
    return v;
`endif
  endfunction

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    cyc         = 0;
    pwm_m       = 0;
    rst         = 1'b1;
    bus.req     = '0;
    bus.pattern = {8'h5A, 8'hC3, 8'h3C, 8'hA5};
`ifdef LED_ARBITER_PWM_EN
    bus.duty    = 4'd15;
`endif

    do_reset();
    check_val("rst_grant", bus.grant, 32'h0);
    check_val("rst_led",   bus.led,   32'h0);
    check_val("rst_busy",  bus.busy,  32'h0);

    bus.req = 4'b0001;
    run_to(1);
    check_val("first_grant", bus.grant, 32'h1);
    check_val("first_led",   bus.led,   exp_led(8'hA5));
    check_val("first_busy",  bus.busy,  32'h1);

    bus.pattern[7:0] = 8'h11;
    run_to(2);
    check_val("live_pattern", bus.led, exp_led(8'h11));

    bus.pattern[7:0] = 8'hA5;
    bus.req = 4'b0011;
    run_to(8);
    check_val("hold_no_early", bus.grant, 32'h1);
    run_to(9);
    check_val("preempt_grant", bus.grant, 32'h2);
    check_val("preempt_led",   bus.led,   exp_led(8'h3C));
    check_val("preempt_busy",  bus.busy,  32'h1);

    bus.req = 4'b1111;
    run_to(16);
    check_val("rot1_hold",  bus.grant, 32'h2);
    run_to(17);
    check_val("rot_to2",    bus.grant, 32'h4);
    check_val("rot_to2_led", bus.led,  exp_led(8'hC3));
    run_to(24);
    check_val("rot2_hold",  bus.grant, 32'h4);
    run_to(25);
    check_val("rot_to3",    bus.grant, 32'h8);
    check_val("rot_to3_led", bus.led,  exp_led(8'h5A));
    run_to(33);
    check_val("rot_to0",    bus.grant, 32'h1);
    check_val("rot_to0_led", bus.led,  exp_led(8'hA5));
    run_to(41);
    check_val("rot_to1",    bus.grant, 32'h2);

    bus.req = 4'b0101;
    run_to(42);
    check_val("release_to2", bus.grant, 32'h4);
    run_to(45);
    check_val("own2_midhold", bus.grant, 32'h4);
    bus.req = 4'b0001;
    run_to(46);
    check_val("release_to0",     bus.grant, 32'h1);
    check_val("release_to0_led", bus.led,   exp_led(8'hA5));

    run_to(48);
    bus.req = 4'b0000;
    run_to(49);
    check_val("idle_grant", bus.grant, 32'h0);
    check_val("idle_led",   bus.led,   32'h0);
    check_val("idle_busy",  bus.busy,  32'h0);

    bus.req = 4'b0100;
    run_to(50);
    check_val("single_grant", bus.grant, 32'h4);
    run_to(62);
    check_val("single_persist", bus.grant, 32'h4);
    bus.req = 4'b0110;
    run_to(63);
    check_val("late_preempt",     bus.grant, 32'h2);
    check_val("late_preempt_led", bus.led,   exp_led(8'h3C));

    run_to(64);
    rst     = 1'b1;
    bus.req = 4'b0101;
    step();
    check_val("midrst_grant", bus.grant, 32'h0);
    check_val("midrst_led",   bus.led,   32'h0);
    check_val("midrst_busy",  bus.busy,  32'h0);
    cyc = 0;
    rst = 1'b0;
    run_to(1);
    check_val("post_rst_grant", bus.grant, 32'h1);
    check_val("post_rst_led",   bus.led,   exp_led(8'hA5));

`ifdef LED_ARBITER_PWM_EN
    begin
      int on_cnt;
      bus.req          = 4'b0001;
      bus.pattern[7:0] = 8'hFF;
      bus.duty         = 4'd4;
      step();
      on_cnt = 0;
      for (int i = 0; i < 16; i++) begin
        step();
        if (bus.led == 8'hFF) on_cnt++;
      end
      check_val("pwm_on_cycles", 32'(on_cnt), 32'd4);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
